// File: rtl/trojan_key_monitor_if.sv
// rtl/trojan_key_monitor_if.sv - sample and status bundle for the key-path tamper monitor
// Purpose: carries one sampled key transfer (golden key, observed key, trigger
//          word, valid, clear) into the monitor and its status/capture outputs out.
// Modports:
//   master - key-path side: drives sample_valid/key_ref/key_obs/trigger/clear,
//            reads alarm/mismatch_count/capture_valid/diff_capture/bit_capture/trig_capture
//   slave  - monitor side: the mirror image of master
interface trojan_key_monitor_if #(
    parameter int KEY_W  = 56,
    parameter int TRIG_W = 32,
    parameter int CNT_W  = 8
);
    logic              sample_valid;
    logic [KEY_W-1:0]  key_ref;
    logic [KEY_W-1:0]  key_obs;
    logic [TRIG_W-1:0] trigger;
    logic              clear;
    logic              alarm;
    logic [CNT_W-1:0]  mismatch_count;
    logic              capture_valid;
    logic [KEY_W-1:0]  diff_capture;
    logic [5:0]        bit_capture;
    logic [TRIG_W-1:0] trig_capture;

    modport master (
        output sample_valid, key_ref, key_obs, trigger, clear,
        input  alarm, mismatch_count, capture_valid, diff_capture, bit_capture, trig_capture
    );

    modport slave (
        input  sample_valid, key_ref, key_obs, trigger, clear,
        output alarm, mismatch_count, capture_valid, diff_capture, bit_capture, trig_capture
    );
endinterface

// File: rtl/trojan_key_monitor.sv
// rtl/trojan_key_monitor.sv - passive tamper observer for the 56-bit DES key path
// Purpose: compares the golden key against the key leaving the modification
//          stage on every sampled transfer, counts mismatches (saturating),
//          captures the first mismatch and raises a sticky alarm at THRESH.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - trojan_key_monitor_if.slave: sample inputs, clear, status/captures
// Pipeline: stage 1 registers the diff, stage 2 flags the mismatch and finds
//           the lowest flipped bit, stage 3 updates counters/captures/FSM.
//           Outputs reflect a sample three rising edges after it is taken.
module trojan_key_monitor #(
    parameter int KEY_W  = 56,
    parameter int TRIG_W = 32,
    parameter int CNT_W  = 8,
    parameter int THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    trojan_key_monitor_if.slave  bus
);

    typedef enum logic {
        MONITOR = 1'b0,
        ALARM   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    // stage 1
    logic              v1_q;
    logic [KEY_W-1:0]  diff1_q;
    logic [TRIG_W-1:0] trig1_q;

    // stage 2
    logic              mm2_q;
    logic [KEY_W-1:0]  diff2_q;
    logic [TRIG_W-1:0] trig2_q;
    logic [5:0]        idx2_q;
    logic [5:0]        idx2_d;

    // stage 3 / outputs
    state_t            state_q;
    logic              alarm_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              capv_q;
    logic [KEY_W-1:0]  diff_cap_q;
    logic [5:0]        bit_cap_q;
    logic [TRIG_W-1:0] trig_cap_q;

    // Lowest set bit of the stage-1 diff. Scanning from the top down lets the
    // lowest set bit be the last assignment and therefore win; 0 when diff=0.
    always_comb begin
        idx2_d = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (diff1_q[i]) begin
                idx2_d = 6'(i);
            end
        end
    end

    // Saturating increment: stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (mm2_q && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            diff1_q    <= '0;
            trig1_q    <= '0;
            mm2_q      <= 1'b0;
            diff2_q    <= '0;
            trig2_q    <= '0;
            idx2_q     <= '0;
            state_q    <= MONITOR;
            alarm_q    <= 1'b0;
            count_q    <= '0;
            capv_q     <= 1'b0;
            diff_cap_q <= '0;
            bit_cap_q  <= '0;
            trig_cap_q <= '0;
        end else begin
            // Data registers follow the inputs unconditionally; only the valid
            // bits decide whether anything downstream acts on them.
            diff1_q <= bus.key_ref ^ bus.key_obs;
            trig1_q <= bus.trigger;
            diff2_q <= diff1_q;
            trig2_q <= trig1_q;
            idx2_q  <= idx2_d;

            if (bus.clear) begin
                // Flushing both valid bits drops the sample being taken now
                // and everything already in flight; it also wins over the
                // mismatch currently sitting in stage 2.
                v1_q       <= 1'b0;
                mm2_q      <= 1'b0;
                state_q    <= MONITOR;
                alarm_q    <= 1'b0;
                count_q    <= '0;
                capv_q     <= 1'b0;
                diff_cap_q <= '0;
                bit_cap_q  <= '0;
                trig_cap_q <= '0;
            end else begin
                v1_q  <= bus.sample_valid;
                mm2_q <= v1_q & (|diff1_q);

                if (mm2_q) begin
                    count_q <= count_d;
                    if (!capv_q) begin
                        capv_q     <= 1'b1;
                        diff_cap_q <= diff2_q;
                        bit_cap_q  <= idx2_q;
                        trig_cap_q <= trig2_q;
                    end
                end

                case (state_q)
                    MONITOR: begin
                        // Compare the post-update count so alarm rises on the
                        // same edge the count reaches the threshold.
                        if (mm2_q && (count_d >= THRESH_C)) begin
                            state_q <= ALARM;
                            alarm_q <= 1'b1;
                        end
                    end
                    ALARM: begin
                        state_q <= ALARM;
                        alarm_q <= 1'b1;
                    end
                    default: begin
                        state_q <= MONITOR;
                        alarm_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.alarm          = alarm_q;
    assign bus.mismatch_count = count_q;
    assign bus.capture_valid  = capv_q;
    assign bus.diff_capture   = diff_cap_q;
    assign bus.bit_capture    = bit_cap_q;
    assign bus.trig_capture   = trig_cap_q;

endmodule

// File: tb/tb_trojan_key_monitor.sv
// tb/tb_trojan_key_monitor.sv - self-checking bench for trojan_key_monitor
module tb_trojan_key_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [55:0] in_ref;
    logic [55:0] in_obs;
    logic [31:0] in_trig;
    logic        in_valid;
    logic        in_clear;

    trojan_key_monitor_if #(.KEY_W(56), .TRIG_W(32), .CNT_W(8)) bus0 ();
    trojan_key_monitor_if #(.KEY_W(56), .TRIG_W(32), .CNT_W(4)) bus1 ();

    assign bus0.sample_valid = in_valid;
    assign bus0.key_ref      = in_ref;
    assign bus0.key_obs      = in_obs;
    assign bus0.trigger      = in_trig;
    assign bus0.clear        = in_clear;
    assign bus1.sample_valid = in_valid;
    assign bus1.key_ref      = in_ref;
    assign bus1.key_obs      = in_obs;
    assign bus1.trigger      = in_trig;
    assign bus1.clear        = in_clear;

    trojan_key_monitor #(.KEY_W(56), .TRIG_W(32), .CNT_W(8), .THRESH(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    trojan_key_monitor #(.KEY_W(56), .TRIG_W(32), .CNT_W(4), .THRESH(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    // Samples wait two edges before they are judged; both DUTs see the same
    // stimulus so one pending queue serves both, with per-instance results.
    typedef struct {
        bit          v;
        logic [55:0] d;
        logic [31:0] t;
    } samp_t;

    samp_t       pend[$];
    int          m_cnt[2];
    bit          m_capv[2];
    logic [55:0] m_diff[2];
    int          m_bit[2];
    logic [31:0] m_trig[2];
    bit          m_alarm[2];
    int          thr[2]  = '{1, 3};
    int          maxc[2] = '{255, 15};

    function automatic int lowbit(logic [55:0] d);
        int k = 0;
        if (d == 0) return 0;
        while (d[0] == 1'b0) begin
            d = d >> 1;
            k++;
        end
        return k;
    endfunction

    function automatic void model_zero();
        samp_t e;
        e.v = 0; e.d = '0; e.t = '0;
        pend = '{};
        pend.push_back(e);
        pend.push_back(e);
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_capv[i] = 0; m_diff[i] = '0;
            m_bit[i] = 0; m_trig[i] = '0; m_alarm[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        samp_t e;
        samp_t n;
        if (in_clear) begin
            model_zero();
            return;
        end
        e = pend.pop_front();
        if (e.v && e.d != 0) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = (m_cnt[i] < maxc[i]) ? m_cnt[i] + 1 : maxc[i];
                if (!m_capv[i]) begin
                    m_capv[i] = 1; m_diff[i] = e.d;
                    m_bit[i] = lowbit(e.d); m_trig[i] = e.t;
                end
                if (m_cnt[i] >= thr[i]) m_alarm[i] = 1;
            end
        end
        n.v = in_valid; n.d = in_ref ^ in_obs; n.t = in_trig;
        pend.push_back(n);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_zero();
        else model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] a, c, cv, d, b, t;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                a = 64'(bus0.alarm); c = 64'(bus0.mismatch_count); cv = 64'(bus0.capture_valid);
                d = 64'(bus0.diff_capture); b = 64'(bus0.bit_capture); t = 64'(bus0.trig_capture);
            end else begin
                a = 64'(bus1.alarm); c = 64'(bus1.mismatch_count); cv = 64'(bus1.capture_valid);
                d = 64'(bus1.diff_capture); b = 64'(bus1.bit_capture); t = 64'(bus1.trig_capture);
            end
            chk($sformatf("%s.alarm%0d", tag, i), a, 64'(m_alarm[i]));
            chk($sformatf("%s.count%0d", tag, i), c, 64'(m_cnt[i]));
            chk($sformatf("%s.capv%0d", tag, i), cv, 64'(m_capv[i]));
            chk($sformatf("%s.diff%0d", tag, i), d, 64'(m_diff[i]));
            chk($sformatf("%s.bit%0d", tag, i), b, 64'(m_bit[i]));
            chk($sformatf("%s.trig%0d", tag, i), t, 64'(m_trig[i]));
        end
    endtask

    task automatic drive(input bit v, input logic [55:0] r, input logic [55:0] o,
                         input logic [31:0] t, input bit c);
        in_valid = v; in_ref = r; in_obs = o; in_trig = t; in_clear = c;
    endtask

    function automatic logic [55:0] rnd56();
        return 56'({$urandom(), $urandom()});
    endfunction

    task automatic do_clear();
        drive(0, '0, '0, '0, 1);
        tick();
        in_clear = 0;
    endtask

    // ---------------- single-sample vector table ----------------
    typedef struct {
        logic [55:0] r;
        logic [55:0] o;
        logic [31:0] t;
        bit          v;
        int          e_cnt;
        bit          e_capv;
        logic [55:0] e_diff;
        int          e_bit;
        bit          e_alarm;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] r;
        vt[0] = '{56'h00_0000_0000_0001, 56'h0, 32'h0000_0005, 1, 1, 1, 56'h1, 0, 1};
        vt[1] = '{56'h12_3456_789A_BCDE, 56'h12_3456_789A_BCDE, 32'hDEAD_BEEF, 1, 0, 0, 56'h0, 0, 0};
        vt[2] = '{56'h80_0000_0000_0000, 56'h0, 32'h1234_5678, 1, 1, 1, 56'h80_0000_0000_0000, 55, 1};
        vt[3] = '{56'h00_0000_0000_00F0, 56'h00_0000_0000_000F, 32'hA5A5_0001, 1, 1, 1, 56'hFF, 0, 1};
        vt[4] = '{56'h04_0100_0000_0000, 56'h0, 32'h0000_0040, 1, 1, 1, 56'h04_0100_0000_0000, 40, 1};
        vt[5] = '{56'hFF_FFFF_FFFF_FFFF, 56'h0, 32'h1, 0, 0, 0, 56'h0, 0, 0};

        // reset state, checked while rst is still asserted
        rst = 1'b1;
        drive(0, '0, '0, '0, 0);
        model_zero();
        #1;
        chk("rst.alarm", 64'(bus0.alarm), 64'h0);
        chk("rst.count", 64'(bus0.mismatch_count), 64'h0);
        chk("rst.capv", 64'(bus0.capture_valid), 64'h0);
        chk("rst.diff", 64'(bus0.diff_capture), 64'h0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // table-driven single samples, each after a clear
        foreach (vt[k]) begin
            do_clear();
            drive(vt[k].v, vt[k].r, vt[k].o, vt[k].t, 0);
            tick();
            drive(0, '0, '0, '0, 0);
            tick(); tick();
            chk($sformatf("vec%0d.count", k), 64'(bus0.mismatch_count), 64'(vt[k].e_cnt));
            chk($sformatf("vec%0d.capv", k), 64'(bus0.capture_valid), 64'(vt[k].e_capv));
            chk($sformatf("vec%0d.diff", k), 64'(bus0.diff_capture), 64'(vt[k].e_diff));
            chk($sformatf("vec%0d.bit", k), 64'(bus0.bit_capture), 64'(vt[k].e_bit));
            chk($sformatf("vec%0d.trig", k), 64'(bus0.trig_capture),
                vt[k].e_capv ? 64'(vt[k].t) : 64'h0);
            chk($sformatf("vec%0d.alarm", k), 64'(bus0.alarm), 64'(vt[k].e_alarm));
            check_all($sformatf("vec%0d", k));
        end

        // no tamper: 100 matching samples
        do_clear();
        for (int i = 0; i < 100; i++) begin
            r = rnd56();
            drive(1, r, r, $urandom(), 0);
            tick();
        end
        drive(0, '0, '0, '0, 0);
        tick(); tick();
        chk("clean.count", 64'(bus0.mismatch_count), 64'h0);
        chk("clean.alarm", 64'(bus0.alarm), 64'h0);
        chk("clean.capv", 64'(bus0.capture_valid), 64'h0);
        check_all("clean");

        // THRESH=3 on dut1: mismatches on samples 1, 4, 9
        do_clear();
        for (int s = 1; s <= 9; s++) begin
            r = rnd56();
            case (s)
                1: drive(1, r, r ^ 56'h80_0000_0000_0000, 32'h0000_0001, 0);
                4: drive(1, r, r ^ 56'h00_0000_0000_0008, 32'h0000_0004, 0);
                9: drive(1, r, r ^ 56'h00_0000_0010_0000, 32'h0000_0009, 0);
                default: drive(1, r, r, $urandom(), 0);
            endcase
            tick();
        end
        drive(0, '0, '0, '0, 0);
        tick();
        chk("thr.alarm_early", 64'(bus1.alarm), 64'h0);
        chk("thr.count_early", 64'(bus1.mismatch_count), 64'h2);
        tick();
        chk("thr.alarm", 64'(bus1.alarm), 64'h1);
        chk("thr.count", 64'(bus1.mismatch_count), 64'h3);
        chk("thr.bit", 64'(bus1.bit_capture), 64'd55);
        chk("thr.trig", 64'(bus1.trig_capture), 64'h1);
        check_all("thr");

        // saturation: CNT_W=4 instance holds at 15
        do_clear();
        for (int i = 0; i < 20; i++) begin
            r = rnd56();
            drive(1, r, ~r, 32'(i), 0);
            tick();
        end
        drive(0, '0, '0, '0, 0);
        tick(); tick();
        chk("sat.count1", 64'(bus1.mismatch_count), 64'd15);
        chk("sat.alarm1", 64'(bus1.alarm), 64'h1);
        chk("sat.count0", 64'(bus0.mismatch_count), 64'd20);
        for (int i = 0; i < 3; i++) begin
            drive(1, 56'h1, 56'h3, 32'h77, 0);
            tick();
        end
        drive(0, '0, '0, '0, 0);
        tick(); tick();
        chk("sat.hold1", 64'(bus1.mismatch_count), 64'd15);
        chk("sat.trig1", 64'(bus1.trig_capture), 64'h0);
        check_all("sat");

        // clear collides with a mismatch reaching stage 3, more in flight
        do_clear();
        drive(1, 56'h5, 56'h4, 32'hA, 0); tick();
        drive(1, 56'h6, 56'h4, 32'hB, 0); tick();
        drive(1, 56'h7, 56'h4, 32'hC, 1); tick();
        drive(0, '0, '0, '0, 0);
        tick(); tick(); tick();
        chk("clr.count", 64'(bus0.mismatch_count), 64'h0);
        chk("clr.capv", 64'(bus0.capture_valid), 64'h0);
        chk("clr.alarm", 64'(bus0.alarm), 64'h0);
        check_all("clr");
        drive(1, 56'h0, 56'h100, 32'hD, 0); tick();
        drive(0, '0, '0, '0, 0);
        tick(); tick();
        chk("clr.next_count", 64'(bus0.mismatch_count), 64'h1);
        chk("clr.next_bit", 64'(bus0.bit_capture), 64'd8);
        chk("clr.next_alarm1", 64'(bus1.alarm), 64'h0);
        check_all("clr_next");

        // async reset mid-stream discards in-flight samples
        do_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1, 56'h3, 56'h1, 32'(i), 0);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.alarm", 64'(bus0.alarm), 64'h0);
        chk("mrst.count", 64'(bus0.mismatch_count), 64'h0);
        chk("mrst.capv", 64'(bus0.capture_valid), 64'h0);
        chk("mrst.diff", 64'(bus0.diff_capture), 64'h0);
        model_zero();
        #1;
        rst = 1'b0;
        drive(0, '0, '0, '0, 0);
        tick(); tick(); tick();
        chk("mrst.after_count", 64'(bus0.mismatch_count), 64'h0);
        check_all("mrst");

        // randomized traffic against the model
        do_clear();
        for (int i = 0; i < 400; i++) begin
            r = rnd56();
            case ($urandom_range(0, 7))
                0: drive($urandom_range(0, 3) != 0, r, r ^ (56'h1 << $urandom_range(0, 55)), $urandom(), 0);
                1: drive($urandom_range(0, 3) != 0, r, rnd56(), $urandom(), 0);
                default: drive($urandom_range(0, 3) != 0, r, r, $urandom(), 0);
            endcase
            if ($urandom_range(0, 59) == 0) in_clear = 1;
            tick();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
